// File: rtl/dti_serialize_pkg.sv
// Shared types and helpers for the dti word-to-element serializer.
package dti_serialize_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Upper bounds for the generic element extractor below.
  localparam int unsigned MAX_WORD_W = 1024;
  localparam int unsigned MAX_ELEM_W = 64;

  function automatic int unsigned lw_of(input int unsigned num);
    return 32'($clog2(num + 1));
  endfunction

  function automatic logic [MAX_ELEM_W-1:0] elem_at(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           idx,
    input int unsigned           width
  );
    return MAX_ELEM_W'(word >> (idx * width));
  endfunction

endpackage

// File: rtl/dti_serialize.sv
// Splits a packed word of up to NUM elements into one-element dti transfers,
// lowest index first, flagging the last element with eot.
module dti_serialize
  import dti_serialize_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned NUM   = 4,
  localparam int unsigned LW    = lw_of(NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [NUM*WIDTH+LW-1:0] din_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [WIDTH:0]        dout_data
);

  localparam int unsigned IW = (NUM > 1) ? 32'($clog2(NUM)) : 1;
  localparam int unsigned DW = NUM * WIDTH;

  state_e          state_q, state_d;
  logic [DW-1:0]   word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   cnt_q, cnt_d;

  logic [LW-1:0]   din_len;
  logic [LW-1:0]   din_cnt;
  logic            last;
  logic            dout_hs;
  logic            load;
  logic [WIDTH-1:0] elem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Oversized lengths are clamped to the number of element slots.
  assign din_len = din_data[DW +: LW];
  assign din_cnt = (din_len > LW'(NUM)) ? LW'(NUM) : din_len;

  assign elem = WIDTH'(elem_at(MAX_WORD_W'(word_q), 32'(idx_q), WIDTH));

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dout_valid = (state_q == SEND);
    last       = (LW'(idx_q) == (cnt_q - LW'(1)));
    dout_data  = {last, elem};
    dout_hs    = dout_valid & dout_ready;
    // Ready passes through on the last-element handshake so words chain with no bubble.
    din_ready  = rst & ((state_q == IDLE) | (dout_hs & last));
    load       = din_valid & din_ready;

    if (load) begin
      word_d  = din_data[DW-1:0];
      cnt_d   = din_cnt;
      idx_d   = '0;
      state_d = (din_cnt != '0) ? SEND : IDLE;
    end else if (dout_hs) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        idx_d = IW'(idx_q + IW'(1));
      end
    end
  end

endmodule
